hex_display_mux: RTL and testbench
==================================

HEX_DISPLAY_MUX -- requirements
Module: hex_display_mux

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports clk and reset.
REQ-002 Parameter NUM_DIGITS, default 4, SHALL set the number of hex digits driven (1..8).
REQ-003 Parameter DIV_COUNT, default 50000, SHALL set the clk cycles each digit stays selected (>=2).
REQ-004 Parameter ACTIVE_LOW, default 1, SHALL make seg, dp and an active-low when 1 and active-high when 0.
REQ-005 Parameter LZ_BLANK, default 1, SHALL enable leading-zero blanking when 1.
REQ-006 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- enable  in  1  scan enable
- load  in  1  capture value/dp_in this cycle
- value  in  4*NUM_DIGITS  hex digits; digit k = value[4k+3:4k], digit 0 least significant
- dp_in  in  NUM_DIGITS  per-digit decimal point request
- seg  out  7  segments {a,b,c,d,e,f,g}, seg[6]=a
- dp  out  1  decimal point of the selected digit
- an  out  NUM_DIGITS  digit select, an[k] drives digit k
- frame_done  out  1  one-cycle pulse per completed scan frame

Function
REQ-007 On load=1, value and dp_in SHALL be latched into internal registers (val_r, dp_r) at that clock edge; the display SHALL use only val_r/dp_r.
REQ-008 A divider counter SHALL count 0..DIV_COUNT-1 while enable=1 and wrap to 0.
REQ-009 At terminal count, digit index idx SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0.
REQ-010 frame_done SHALL be 1 for exactly the cycle following the edge at which idx wraps to 0, and 0 otherwise.
REQ-011 seg, dp and an SHALL be registered: each SHALL reflect idx, val_r and dp_r as they stood in the previous cycle (1-cycle latency).
REQ-012 Active-low encoding of seg for nibble 0..F SHALL be: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0001100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000; ACTIVE_LOW=0 SHALL use the bitwise inverse.
REQ-013 Exactly one an bit, an[idx], SHALL be active while enable=1 and not in reset.
REQ-014 With LZ_BLANK=1, digit k>0 SHALL be blanked (all segments inactive) when digits NUM_DIGITS-1..k of val_r are all zero; digit 0 SHALL never be blanked.
REQ-015 dp SHALL equal dp_r[idx] (polarity per ACTIVE_LOW), including for blanked digits.
REQ-016 With enable=0, the counter and idx SHALL hold, all of seg, dp and an SHALL be inactive, and frame_done SHALL be 0; re-asserting enable SHALL resume from the held count and digit.
REQ-017 load SHALL be accepted regardless of enable; a load coinciding with a digit advance SHALL display the new value on the newly selected digit.

Reset
REQ-018 With reset=1 at a clock edge, the counter, idx, val_r and dp_r SHALL become 0, frame_done SHALL become 0, and seg, dp and every an bit SHALL become inactive (1 when ACTIVE_LOW=1).
REQ-019 reset SHALL take priority over load and enable in the same cycle; reset asserted mid-frame SHALL abort the scan, and scanning SHALL restart at digit 0, count 0.

Verification (NUM_DIGITS=4, DIV_COUNT=4, ACTIVE_LOW=1 unless stated)
REQ-020 Reset: hold reset 2 cycles -> seg=1111111, dp=1, an=1111, frame_done=0.
REQ-021 Scan: load value=16'h12AF, dp_in=4'b0100, enable=1 -> an=1110 with seg=0111000 (F) for 4 cycles, then an=1101 with seg=0001000 (A), then an=1011 with seg=0010010 (2) and dp=0, then an=0111 with seg=1001111 (1).
REQ-022 Blanking: value=16'h0005 -> digits 3..1 show seg=1111111 and digit 0 shows 0100100; value=16'h0000 -> digit 0 shows 0000001; LZ_BLANK=0 -> all four digits show 0000001.
REQ-023 Frame pulse: continuous enable -> frame_done high for one cycle every 16 cycles, coincident with the first output cycle of an=1110.
REQ-024 Enable gap: drop enable during digit 2 for 10 cycles -> an=1111, seg=1111111 throughout; on restore, digit 2 resumes and completes its remaining count.
REQ-025 Reset priority: assert reset and load (value=16'hFFFF) together mid-frame -> after release val_r=0, scan restarts at an=1110 showing 0000001; ACTIVE_LOW=0 rerun -> all outputs inverted.

Source files
------------

// File: rtl/hex_display_mux.sv
// hex_display_mux: time-multiplexed driver for a bank of 7-segment hex digits.
// Each digit stays selected for DIV_COUNT clocks. Captured value/dp_in are
// shown with leading-zero blanking and a programmable output polarity.
// Decode and blanking work in active-low form; polarity is applied only at
// the output registers.
module hex_display_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_COUNT  = 50000,
    parameter int ACTIVE_LOW = 1,
    parameter int LZ_BLANK   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int CW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic INV = (ACTIVE_LOW == 0);

    localparam logic [6:0]            SEG_OFF = {7{~INV}};
    localparam logic                  DP_OFF  = ~INV;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{~INV}};

    logic [4*NUM_DIGITS-1:0] val_r;
    logic [NUM_DIGITS-1:0]   dp_r;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    wrap_q;

    logic                    tc;
    logic                    idx_last;
    logic [3:0]              nibble;
    logic                    dp_sel;
    logic                    blank_sel;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic [NUM_DIGITS-1:0]   an_al;
    logic [6:0]              seg_dec;
    logic [6:0]              seg_al;
    logic                    zero_run;

    assign tc       = (cnt == CW'(DIV_COUNT - 1));
    assign idx_last = (idx == IW'(NUM_DIGITS - 1));

    // Select the current digit, its dp request, its one-hot anode and whether
    // every digit from the top down to it is zero.
    always_comb begin
        nibble    = 4'h0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        an_al     = '1;
        lead_zero = '0;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run & (val_r[4*k +: 4] == 4'h0);
            lead_zero[k] = zero_run;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nibble    = val_r[4*k +: 4];
                dp_sel    = dp_r[k];
                blank_sel = lead_zero[k];
                an_al[k]  = 1'b0;
            end
        end
    end

    // Hex to active-low segment pattern {a,b,c,d,e,f,g}, with blanking.
    always_comb begin
        seg_dec = 7'b1111111;
        case (nibble)
            4'h0: seg_dec = 7'b0000001;
            4'h1: seg_dec = 7'b1001111;
            4'h2: seg_dec = 7'b0010010;
            4'h3: seg_dec = 7'b0000110;
            4'h4: seg_dec = 7'b1001100;
            4'h5: seg_dec = 7'b0100100;
            4'h6: seg_dec = 7'b0100000;
            4'h7: seg_dec = 7'b0001111;
            4'h8: seg_dec = 7'b0000000;
            4'h9: seg_dec = 7'b0001100;
            4'hA: seg_dec = 7'b0001000;
            4'hB: seg_dec = 7'b1100000;
            4'hC: seg_dec = 7'b0110001;
            4'hD: seg_dec = 7'b1000010;
            4'hE: seg_dec = 7'b0110000;
            4'hF: seg_dec = 7'b0111000;
            default: seg_dec = 7'b1111111;
        endcase
        seg_al = seg_dec;
        if ((LZ_BLANK != 0) && (idx != '0) && blank_sel) begin
            seg_al = 7'b1111111;
        end
    end

    // Capture the displayed value; load works independently of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            val_r <= '0;
            dp_r  <= '0;
        end else if (load) begin
            val_r <= value;
            dp_r  <= dp_in;
        end
    end

    // Dwell counter and digit index; both hold while scanning is disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= enable & tc & idx_last;
            if (enable) begin
                if (tc) begin
                    cnt <= '0;
                    idx <= idx_last ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Output registers. frame_done goes through the same one-cycle delay as
    // seg/an so the pulse lines up with the first output cycle of digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else if (enable) begin
            seg        <= seg_al ^ {7{INV}};
            dp         <= ~dp_sel ^ INV;
            an         <= an_al ^ {NUM_DIGITS{INV}};
            frame_done <= wrap_q;
        end else begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hex_display_mux.sv
// Testbench for hex_display_mux: three instances (default, no blanking,
// active-high) share stimulus; a reference model feeds a scoreboard queue
// and directed steps add fixed-value checks.
module tb_hex_display_mux;

    localparam int N = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset, enable, load;
    logic [15:0] value;
    logic [3:0]  dp_in;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       dp_a, dp_b, dp_c;
    logic [3:0] an_a, an_b, an_c;
    logic       fd_a, fd_b, fd_c;

    always #5 clk = ~clk;

    hex_display_mux #(.NUM_DIGITS(N), .DIV_COUNT(D), .ACTIVE_LOW(1), .LZ_BLANK(1)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a));
    hex_display_mux #(.NUM_DIGITS(N), .DIV_COUNT(D), .ACTIVE_LOW(1), .LZ_BLANK(0)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .seg(seg_b), .dp(dp_b), .an(an_b), .frame_done(fd_b));
    hex_display_mux #(.NUM_DIGITS(N), .DIV_COUNT(D), .ACTIVE_LOW(0), .LZ_BLANK(1)) dut_c (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .seg(seg_c), .dp(dp_c), .an(an_c), .frame_done(fd_c));

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fd;
    } obs_t;

    obs_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int          m_cnt, m_idx;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_wrap;

    logic [6:0] scan_seg [4] = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0001100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    function automatic obs_t predict(input bit al, input bit lz);
        obs_t       o;
        logic [3:0] nib;
        o.seg = 7'b1111111;
        o.dp  = 1'b1;
        o.an  = 4'b1111;
        o.fd  = 1'b0;
        if (!reset && enable) begin
            nib   = m_val[4*m_idx +: 4];
            o.seg = (lz && m_idx > 0 && (m_val >> (4*m_idx)) == 16'h0) ? 7'b1111111 : enc(nib);
            o.dp  = ~m_dp[m_idx];
            o.an  = ~(4'b0001 << m_idx);
            o.fd  = m_wrap;
        end
        if (!al) begin
            o.seg = ~o.seg;
            o.dp  = ~o.dp;
            o.an  = ~o.an;
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_cnt = 0; m_idx = 0; m_val = '0; m_dp = '0; m_wrap = 1'b0;
        end else begin
            if (load) begin
                m_val = value;
                m_dp  = dp_in;
            end
            if (enable) begin
                m_wrap = (m_cnt == D-1) && (m_idx == N-1);
                if (m_cnt == D-1) begin
                    m_cnt = 0;
                    m_idx = (m_idx + 1) % N;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_wrap = 1'b0;
            end
        end
    endtask

    // One clock: push predictions, advance, then pop and compare all three DUTs.
    task automatic tick();
        obs_t e, g;
        sb.push_back(predict(1'b1, 1'b1));
        sb.push_back(predict(1'b1, 1'b0));
        sb.push_back(predict(1'b0, 1'b1));
        @(posedge clk);
        model_step();
        #1;
        e = sb.pop_front(); g = {seg_a, dp_a, an_a, fd_a};
        check("sb_a", 32'(g), 32'(e));
        e = sb.pop_front(); g = {seg_b, dp_b, an_b, fd_b};
        check("sb_b", 32'(g), 32'(e));
        e = sb.pop_front(); g = {seg_c, dp_c, an_c, fd_c};
        check("sb_c", 32'(g), 32'(e));
    endtask

    initial begin
        int fd_seen;
        m_cnt = 0; m_idx = 0; m_val = '0; m_dp = '0; m_wrap = 1'b0;
        reset = 1'b1; enable = 1'b0; load = 1'b0; value = '0; dp_in = '0;

        tick(); tick();
        check("rst_seg", 32'(seg_a), 32'h7F);
        check("rst_dp",  32'(dp_a),  32'h1);
        check("rst_an",  32'(an_a),  32'hF);
        check("rst_fd",  32'(fd_a),  32'h0);

        reset = 1'b0; load = 1'b1; value = 16'h12AF; dp_in = 4'b0100;
        tick();
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("scan_an",  32'(an_a),  32'(~(4'b0001 << (i/4)) & 4'hF));
            check("scan_seg", 32'(seg_a), 32'(scan_seg[i/4]));
            check("scan_dp",  32'(dp_a),  32'((i/4 == 2) ? 0 : 1));
        end

        fd_seen = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (fd_a) begin
                fd_seen++;
                check("fd_an", 32'(an_a), 32'hE);
            end
        end
        check("fd_count", 32'(fd_seen), 32'd2);

        for (int i = 0; i < 10; i++) tick();
        check("pre_gap_an", 32'(an_a), 32'hB);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("gap_an",  32'(an_a),  32'hF);
            check("gap_seg", 32'(seg_a), 32'h7F);
            check("gap_fd",  32'(fd_a),  32'h0);
        end
        enable = 1'b1;
        tick(); check("resume_an0", 32'(an_a), 32'hB);
        tick(); check("resume_an1", 32'(an_a), 32'hB);
        tick(); check("resume_an2", 32'(an_a), 32'h7);

        reset = 1'b1; tick(); reset = 1'b0; enable = 1'b0;
        load = 1'b1; value = 16'h0005; dp_in = 4'b0000;
        tick();
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("blank5_a", 32'(seg_a), 32'((i/4 == 0) ? 7'b0100100 : 7'b1111111));
            check("blank5_b", 32'(seg_b), 32'((i/4 == 0) ? 7'b0100100 : 7'b0000001));
        end
        enable = 1'b0; load = 1'b1; value = 16'h0000;
        tick();
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("blank0_a", 32'(seg_a), 32'((i/4 == 0) ? 7'b0000001 : 7'b1111111));
            check("blank0_b", 32'(seg_b), 32'h01);
        end

        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1; load = 1'b1; value = 16'hFFFF; dp_in = 4'b1111;
        tick();
        check("rp_an_a", 32'(an_a), 32'hF);
        check("rp_an_c", 32'(an_c), 32'h0);
        reset = 1'b0; load = 1'b0;
        tick();
        check("rp_an_a2",  32'(an_a),  32'hE);
        check("rp_seg_a2", 32'(seg_a), 32'h01);
        check("rp_an_c2",  32'(an_c),  32'h1);
        check("rp_seg_c2", 32'(seg_c), 32'h7E);
        check("rp_dp_c2",  32'(dp_c),  32'h0);
        for (int i = 0; i < 4; i++) tick();
        check("rp_an_a3",  32'(an_a),  32'hD);
        check("rp_seg_a3", 32'(seg_a), 32'h7F);
        check("rp_seg_c3", 32'(seg_c), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
